// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Counts BUSY cycles without a memory acknowledge; expired marks the abort cycle.
// The count saturates at TIMEOUT and never wraps.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // cycle counter, cleared whenever the arbiter is not waiting on memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with a timeout watchdog.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority, data first.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  state_t              state, state_nx;
  owner_t              owner, owner_nx;
  logic                grant_d;
  logic                expired;
  logic                mem_req_nx, mem_we_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [DATA_W-1:0]   mem_wdata_nx, if_rdata_nx, d_rdata_nx, fill_data;
  logic                if_ack_nx, d_ack_nx, err_nx;

`ifdef ARB_RR_EN
  owner_t last_grant;

  // remembers who won the most recent grant so ties alternate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWN_IF;
    end else if ((state == IDLE) && (if_req || d_req)) begin
      last_grant <= grant_d ? OWN_D : OWN_IF;
    end else begin
      last_grant <= last_grant;
    end
  end

  assign grant_d = d_req && (!if_req || (last_grant == OWN_IF));
`else
  // the MEM stage holds the older instruction, so data always wins a tie
  assign grant_d = d_req;
`endif

  generate
    if (TIMEOUT != 0) begin : g_wd
      arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != BUSY),
        .enable  (state == BUSY),
        .expired (expired)
      );
    end else begin : g_no_wd
      assign expired = 1'b0;
    end
  endgenerate

  assign fill_data = mem_ack ? mem_rdata : DATA_W'(ABORT_DATA);

  // next state and next values of every registered output
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;
    if_ack_nx    = 1'b0;
    d_ack_nx     = 1'b0;
    err_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nx   = BUSY;
          mem_req_nx = 1'b1;
          if (grant_d) begin
            owner_nx     = OWN_D;
            mem_we_nx    = d_we;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
          end else begin
            owner_nx     = OWN_IF;
            mem_we_nx    = 1'b0;
            mem_addr_nx  = if_addr;
            mem_wdata_nx = '0;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        // an ack in the expiry cycle still counts as a normal completion
        if (mem_ack || expired) begin
          state_nx   = DONE;
          mem_req_nx = 1'b0;
          err_nx     = !mem_ack;
          if (owner == OWN_D) begin
            d_rdata_nx = fill_data;
            d_ack_nx   = 1'b1;
          end else begin
            if_rdata_nx = fill_data;
            if_ack_nx   = 1'b1;
          end
        end else begin
          state_nx = BUSY;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      if_ack    <= if_ack_nx;
      d_ack     <= d_ack_nx;
      err       <= err_nx;
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized traffic
// against a transaction-level reference model (watchdog limit 4).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, if_stall, d_ack, d_stall, mem_req, mem_we, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_if_rdata, exp_d_rdata;
  logic          last_d;
  logic          granted_d;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk1({tag, "_if_ack"}, if_ack, 1'b0);
    chk1({tag, "_d_ack"}, d_ack, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk32({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk32({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  // Model: called in an IDLE cycle with requests set. lat = BUSY cycle (0-based)
  // in which memory acks; lat > TO means memory never answers.
  task automatic txn(input int lat, input logic [DW-1:0] rd);
    logic          gd, e_err;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd, edat;
`ifdef ARB_RR_EN
    gd = d_req && (!if_req || !last_d);
`else
    gd = d_req;
`endif
    last_d    = gd;
    granted_d = gd;
    ea    = gd ? d_addr : if_addr;
    ewe   = gd ? d_we : 1'b0;
    ewd   = d_wdata;
    e_err = 1'b1;
    edat  = 32'hDEAD_BEEF;
    tick();
    for (int c = 0; c <= TO; c++) begin
      chk1("busy_mem_req", mem_req, 1'b1);
      chk32("busy_mem_addr", mem_addr, ea);
      chk1("busy_mem_we", mem_we, ewe);
      if (gd) chk32("busy_mem_wdata", mem_wdata, ewd);
      chk1("busy_if_ack", if_ack, 1'b0);
      chk1("busy_d_ack", d_ack, 1'b0);
      chk1("busy_if_stall", if_stall, if_req);
      chk1("busy_d_stall", d_stall, d_req);
      mem_ack   = (c == lat);
      mem_rdata = (c == lat) ? rd : $urandom();
      if (c == lat) begin
        e_err = 1'b0;
        edat  = rd;
      end
      tick();
      mem_ack = 1'b0;
      if (c == lat) break;
    end
    if (gd) exp_d_rdata = edat;
    else exp_if_rdata = edat;
    chk1("done_if_ack", if_ack, !gd);
    chk1("done_d_ack", d_ack, gd);
    chk1("done_err", err, e_err);
    chk32("done_if_rdata", if_rdata, exp_if_rdata);
    chk32("done_d_rdata", d_rdata, exp_d_rdata);
    chk1("done_mem_req", mem_req, 1'b0);
    chk1("done_if_stall", if_stall, if_req & gd);
    chk1("done_d_stall", d_stall, d_req & !gd);
  endtask

  // DONE -> IDLE, optionally with a stray mem_ack in both cycles
  task automatic idle_step(input logic spur);
    mem_ack = spur;
    tick();
    chk1("idle_mem_req", mem_req, 1'b0);
    chk1("idle_if_ack", if_ack, 1'b0);
    chk1("idle_d_ack", d_ack, 1'b0);
    chk1("idle_err", err, 1'b0);
    chk1("idle_if_stall", if_stall, if_req);
    chk1("idle_d_stall", d_stall, d_req);
  endtask

  task automatic model_reset();
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    last_d       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    granted_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;

    // IF-only read, ack two cycles after mem_req
    if_req = 1'b1; if_addr = 32'h100;
    txn(2, 32'h0050_0093);
    if_req = 1'b0;
    idle_step(1'b0);

    // data store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D;
    txn(3, $urandom());
    d_req = 1'b0; d_we = 1'b0;
    idle_step(1'b1);

    // reset in IDLE, then both requesters contend for four transactions
    rst = 1'b1;
    #1;
    check_reset("rst_idle");
    model_reset();
    tick();
    rst = 1'b0;
    if_req = 1'b1; if_addr = $urandom(); d_req = 1'b1; d_we = 1'b0; d_addr = $urandom();
    d_wdata = $urandom();
    for (int i = 0; i < 4; i++) begin
      txn(int'($urandom_range(0, 2)), $urandom());
      if (granted_d) d_addr = $urandom();
      else if_addr = $urandom();
      if (i == 3) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      idle_step(i[0]);
    end

    // memory never answers
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    txn(TO + 5, $urandom());
    d_req = 1'b0;
    idle_step(1'b0);

    // ack coincides with watchdog expiry
    if_req = 1'b1; if_addr = 32'h200;
    txn(TO, 32'h1234_5678);
    if_req = 1'b0;
    idle_step(1'b0);

    // reset in the second BUSY cycle abandons the fetch
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    chk1("rb_busy1_req", mem_req, 1'b1);
    chk32("rb_busy1_addr", mem_addr, 32'h300);
    tick();
    rst = 1'b1;
    #1;
    check_reset("rst_busy");
    model_reset();
    tick();
    chk1("rb_hold_if_ack", if_ack, 1'b0);
    rst = 1'b0;
    if_addr = 32'h304;
    txn(1, $urandom());
    if_req = 1'b0;
    idle_step(1'b0);

    // randomized traffic
    if_req = 1'b1; if_addr = $urandom();
    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(0, TO + 1)), $urandom());
      if (granted_d || !d_req) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom(); d_wdata = $urandom();
      end
      if (!granted_d || !if_req) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = $urandom();
      end
      if (!if_req && !d_req) begin
        if_req = 1'b1; if_addr = $urandom();
      end
      idle_step(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the CPU's instruction-fetch (IF) requester and its data (MEM-stage load/store) requester. Each requester has its own hold-until-ack handshake and its own stall output, so the pipeline can freeze on either side. The arbiter sits between the pipelined RV32I core and a unified variable-latency memory. A watchdog aborts transactions the memory never acknowledges.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: maximum BUSY cycles without `mem_ack` before an abort; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held high with `if_addr` stable until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched word; valid when `if_ack` is high.
- `if_ack` out 1: one-cycle completion pulse for the fetch.
- `if_stall` out 1: `if_req & ~if_ack`.
- `d_req` in 1: data request; held high with address, write enable and write data stable until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data; valid when `d_ack` is high.
- `d_ack` out 1: one-cycle completion pulse for the data access.
- `d_stall` out 1: `d_req & ~d_ack`.
- `mem_req` out 1: memory request; held until `mem_ack` or abort.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data; valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion from memory.
- `err` out 1: one-cycle pulse, coincident with the owner's ack, when a transaction was aborted by timeout.

## Operation
- FSM states:
  - IDLE: samples `if_req` and `d_req`.
    - If neither is high, stay in IDLE.
    - Otherwise choose an owner, register the `mem_*` outputs from that owner's inputs, reset the watchdog count, and go to BUSY.
  - BUSY: `mem_req` = 1 and all `mem_*` outputs are held stable; the watchdog count increments each cycle.
    - On `mem_ack`: capture `mem_rdata` into the owner's rdata register and go to DONE.
    - On count == TIMEOUT (TIMEOUT ≠ 0) with no `mem_ack`: load `32'hDEAD_BEEF` into the owner's rdata register, set the error flag, and go to DONE.
  - DONE: `mem_req` = 0; the owner's ack = 1 (plus `err` if flagged); go to IDLE.
- Owner selection, fixed priority: data wins over IF, because the MEM stage holds the older instruction.
- A store completes like a load; the owner's rdata register still captures `mem_rdata` and its value is don't-care.
- An rdata register changes only when its owner completes; the other requester's rdata is unchanged.
- Any request seen in IDLE is treated as new. A requester that holds `req` high in the cycle after its ack starts another transaction.
- A `mem_ack` arriving in IDLE or DONE is ignored. The memory must not acknowledge an aborted request after a new `mem_req` has been raised.
- `mem_ack` and timeout in the same cycle: `mem_ack` wins and `err` is not raised.
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_ack`, `d_ack`, `err` all 0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` all 0; watchdog count 0; last-grant register = IF.
- Reset asserted mid-transaction abandons it immediately; no ack is produced.

## Timing
- `if_req` or `d_req` sampled high in IDLE at cycle 0 → `mem_req` high at cycle 1.
- `mem_ack` at cycle k (k ≥ 1) → owner's ack and rdata at cycle k+1.
- IDLE again at cycle k+2.
- Zero-wait memory: one transaction every 3 cycles, with a 2-cycle request-to-ack latency.
- Timeout: `mem_req` is high for TIMEOUT+1 cycles (count runs 0..TIMEOUT); the ack and `err` pulse come in the next cycle.
- Watchdog count width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.
- Ack outputs are registered; the stall outputs are combinational.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - When both requests are high in IDLE, grant the requester that was not granted last.
  - The last-grant register updates on every IDLE→BUSY transition.
- `ARB_RR_EN` undefined: fixed priority, data first; the last-grant register is not built.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum `{IDLE, BUSY, DONE}`.
  - Owner enum `{OWN_IF, OWN_D}`.
  - Constant `ABORT_DATA = 32'hDEAD_BEEF`.
- Sub-module `arb_watchdog`:
  - Clear/enable inputs and an `expired` output.
  - Generated away when TIMEOUT = 0.

## Test plan
- IF-only read, memory acks 2 cycles after `mem_req` (`if_addr`=0x100, `mem_rdata`=0x00500093) → `if_ack` at cycle 4 with `if_rdata`=0x00500093; `d_ack` and `err` stay 0.
- `d_req` store (addr 0x2000, wdata 0xCAFEF00D, `d_we`=1) → `mem_we`=1, `mem_addr`=0x2000, `mem_wdata`=0xCAFEF00D for the whole BUSY period; then `d_ack` pulses once.
- Both requests high in the same cycle, four back-to-back transactions:
  - fixed priority → order D, D, D, D while `d_req` stays high;
  - `ARB_RR_EN` → order D, IF, D, IF.
- TIMEOUT=4, `mem_ack` never arrives → `mem_req` high for 5 cycles; then `d_ack`=1, `err`=1, `d_rdata`=0xDEADBEEF.
- `rst` asserted in the second BUSY cycle → all outputs return to their reset values in the same cycle; after release, a fresh `if_req` completes normally.
- `mem_ack` in the same cycle the watchdog expires → normal ack with captured data and `err`=0.
